sha256_nonce_feeder: RTL and testbench



---
 rtl/sha256_nonce_feeder.sv | 209 ++++++++++++++++++++
 tb/tb_sha256_nonce_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_feeder.sv
// Work-side controller for the unrolled SHA-256 pipeline: issues one nonce per clock,
// pairs returning hashes with nonces and queues winners. Option macro: SHA256_FEEDER_TARGET_EN.
module sha256_nonce_feeder #(
    parameter int unsigned LATENCY = 130
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         work_load,
    input  logic [255:0] midstate,
    input  logic [95:0]  data_tail,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
`ifdef SHA256_FEEDER_TARGET_EN
    input  logic [31:0]  target_mask,
`endif
    output logic [511:0] rx_input,
    output logic [255:0] rx_state,
    input  logic [255:0] hash_in,
    output logic         golden_valid,
    input  logic         golden_ready,
    output logic [31:0]  golden_nonce,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    localparam int unsigned NONCE_W = 32;
    localparam int unsigned WARM_W  = $clog2(LATENCY + 1);
    localparam int unsigned CNT_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [255:0]         mid_q, mid_d;
    logic [95:0]          tail_q, tail_d;
    logic [NONCE_W-1:0]   end_q, end_d;
    logic [NONCE_W-1:0]   issue_q, issue_d;
    logic [NONCE_W-1:0]   check_q, check_d;
    logic [WARM_W-1:0]    warm_q, warm_d;
    logic [NONCE_W-1:0]   head_q, head_d;
    logic [NONCE_W-1:0]   second_q, second_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 gvalid_q, gvalid_d;

    logic                 match_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 unused_hash_c;

`ifdef SHA256_FEEDER_TARGET_EN
    logic [NONCE_W-1:0]   mask_q, mask_d;
    assign match_c = (hash_in[255:224] & mask_q) == '0;
`else
    assign match_c = hash_in[255:224] == '0;
`endif

    assign unused_hash_c = ^hash_in[223:0];
    assign pop_c         = gvalid_q && golden_ready;

    // W4..W15 are the fixed SHA-256 padding for an 80-byte header.
    assign rx_input     = {32'h0000_0280, 320'h0, 32'h8000_0000, issue_q, tail_q};
    assign rx_state     = mid_q;
    assign golden_valid = gvalid_q;
    assign golden_nonce = head_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = ovf_q;

    always_comb begin
        state_d  = state_q;
        mid_d    = mid_q;
        tail_d   = tail_q;
        end_d    = end_q;
        issue_d  = issue_q;
        check_d  = check_q;
        warm_d   = warm_q;
        head_d   = head_q;
        second_d = second_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        push_c   = 1'b0;
`ifdef SHA256_FEEDER_TARGET_EN
        mask_d   = mask_q;
`endif

        if (work_load) begin
            state_d = ST_WARMUP;
            mid_d   = midstate;
            tail_d  = data_tail;
            end_d   = nonce_end;
            issue_d = nonce_start;
            check_d = nonce_start;
            warm_d  = '0;
            ovf_d   = 1'b0;
`ifdef SHA256_FEEDER_TARGET_EN
            mask_d  = target_mask;
`endif
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (issue_q != end_q) begin
                        issue_d = issue_q + NONCE_W'(1);
                    end
                    warm_d = warm_q + WARM_W'(1);
                    if (warm_q == WARM_W'(LATENCY - 1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue_q != end_q) begin
                        issue_d = issue_q + NONCE_W'(1);
                    end
                    push_c = match_c;
                    if (check_q == end_q) begin
                        state_d = ST_DONE;
                    end else begin
                        check_d = check_q + NONCE_W'(1);
                    end
                end
                default: ;
            endcase
        end

        // Two-entry golden buffer; head_q is the visible entry.
        case (count_q)
            CNT_W'(0): begin
                if (push_c) begin
                    head_d  = check_q;
                    count_d = CNT_W'(1);
                end
            end
            CNT_W'(1): begin
                if (push_c && pop_c) begin
                    head_d = check_q;
                end else if (push_c) begin
                    second_d = check_q;
                    count_d  = CNT_W'(2);
                end else if (pop_c) begin
                    count_d = CNT_W'(0);
                end
            end
            default: begin
                if (pop_c) begin
                    head_d = second_q;
                    if (push_c) begin
                        second_d = check_q;
                    end else begin
                        count_d = CNT_W'(1);
                    end
                end else if (push_c) begin
                    ovf_d = 1'b1;
                end
            end
        endcase

        busy_d   = (state_d == ST_WARMUP) || (state_d == ST_RUN);
        done_d   = state_d == ST_DONE;
        gvalid_d = count_d != '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mid_q    <= '0;
            tail_q   <= '0;
            end_q    <= '0;
            issue_q  <= '0;
            check_q  <= '0;
            warm_q   <= '0;
            head_q   <= '0;
            second_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gvalid_q <= 1'b0;
`ifdef SHA256_FEEDER_TARGET_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mid_q    <= mid_d;
            tail_q   <= tail_d;
            end_q    <= end_d;
            issue_q  <= issue_d;
            check_q  <= check_d;
            warm_q   <= warm_d;
            head_q   <= head_d;
            second_q <= second_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gvalid_q <= gvalid_d;
`ifdef SHA256_FEEDER_TARGET_EN
            mask_q   <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_sha256_nonce_feeder.sv
// Self-checking bench for sha256_nonce_feeder: fixed-latency pipeline model plus golden-nonce scoreboard.
module tb_sha256_nonce_feeder;

    localparam int unsigned LAT = 8;
    localparam logic [511:0] RST_RX = {32'h0000_0280, 320'h0, 32'h8000_0000, 128'h0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         work_load = 1'b0;
    logic [255:0] midstate = '0;
    logic [95:0]  data_tail = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic [511:0] rx_input;
    logic [255:0] rx_state;
    logic [255:0] hash_in;
    logic         golden_valid;
    logic         golden_ready = 1'b0;
    logic [31:0]  golden_nonce;
    logic         busy;
    logic         done;
    logic         overflow;
`ifdef SHA256_FEEDER_TARGET_EN
    logic [31:0]  target_mask = 32'hFFFF_FFFF;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] gold_list[$];
    logic [31:0] exp_q[$];
    logic [31:0] pipe_n [LAT];
    logic        pipe_g [LAT];

    sha256_nonce_feeder #(.LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .work_load    (work_load),
        .midstate     (midstate),
        .data_tail    (data_tail),
        .nonce_start  (nonce_start),
        .nonce_end    (nonce_end),
`ifdef SHA256_FEEDER_TARGET_EN
        .target_mask  (target_mask),
`endif
        .rx_input     (rx_input),
        .rx_state     (rx_state),
        .hash_in      (hash_in),
        .golden_valid (golden_valid),
        .golden_ready (golden_ready),
        .golden_nonce (golden_nonce),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    function automatic bit is_gold(input logic [31:0] n);
        foreach (gold_list[i]) if (gold_list[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    // Pipeline model: the hash seen now belongs to the nonce issued LAT cycles ago.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_n[i] <= '0;
                pipe_g[i] <= 1'b0;
            end
        end else begin
            pipe_n[0] <= rx_input[127:96];
            pipe_g[0] <= is_gold(rx_input[127:96]);
            for (int i = 1; i < LAT; i++) begin
                pipe_n[i] <= pipe_n[i-1];
                pipe_g[i] <= pipe_g[i-1];
            end
        end
    end

    assign hash_in = {(pipe_g[LAT-1] ? 32'h0 : (32'h8000_0000 | pipe_n[LAT-1])), {7{pipe_n[LAT-1]}}};

    task automatic load_work(input logic [31:0] s, input logic [31:0] e);
        midstate    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        data_tail   = {$urandom, $urandom, $urandom};
        nonce_start = s;
        nonce_end   = e;
        work_load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        work_load   = 1'b0;
    endtask

    task automatic fill_expected(input logic [31:0] s, input int n);
        logic [31:0] v;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            v = s + 32'(i);
            if (is_gold(v)) exp_q.push_back(v);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (golden_valid !== 1'b0) begin errors++; $display("FAIL reset_gvalid got=%b exp=0", golden_valid); end
        checks++; if (golden_nonce !== 32'h0) begin errors++; $display("FAIL reset_gnonce got=%h exp=0", golden_nonce); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (rx_state !== 256'h0) begin errors++; $display("FAIL reset_rx_state got=%h exp=0", rx_state); end
        checks++; if (rx_input !== RST_RX) begin errors++; $display("FAIL reset_rx_input got=%h exp=%h", rx_input, RST_RX); end
    endtask

    task automatic test_basic;
        logic [31:0] e;
        logic [31:0] exp_w3;
        int n = 4;
        gold_list = '{32'h12};
        fill_expected(32'h10, n);
        golden_ready = 1'b1;
        load_work(32'h10, 32'h13);
        checks++; if (rx_state !== midstate) begin errors++; $display("FAIL basic_rx_state got=%h exp=%h", rx_state, midstate); end
        checks++; if (rx_input[95:0] !== data_tail) begin errors++; $display("FAIL basic_tail got=%h exp=%h", rx_input[95:0], data_tail); end
        checks++; if (rx_input[511:128] !== RST_RX[511:128]) begin errors++; $display("FAIL basic_pad got=%h", rx_input[511:128]); end
        for (int c = 0; c <= int'(LAT) + n + 1; c++) begin
            if (c < 6) begin
                exp_w3 = (c < 4) ? 32'h10 + 32'(c) : 32'h13;
                checks++; if (rx_input[127:96] !== exp_w3) begin errors++; $display("FAIL basic_w3 c=%0d got=%h exp=%h", c, rx_input[127:96], exp_w3); end
            end
            checks++; if (busy !== (c < int'(LAT) + n)) begin errors++; $display("FAIL basic_busy c=%0d got=%b", c, busy); end
            checks++; if (done !== (c >= int'(LAT) + n)) begin errors++; $display("FAIL basic_done c=%0d got=%b", c, done); end
            if (golden_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL basic_extra got=%h exp=none", golden_nonce); end
                else begin
                    e = exp_q.pop_front();
                    if (golden_nonce !== e) begin errors++; $display("FAIL basic_gnonce got=%h exp=%h", golden_nonce, e); end
                    checks++; if (c != int'(LAT) + 1 + int'(e - 32'h10)) begin errors++; $display("FAIL basic_gtime got=%0d exp=%0d", c, int'(LAT) + 1 + int'(e - 32'h10)); end
                end
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing got=%0d exp=0", exp_q.size()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_wrap;
        logic [31:0] e;
        logic [31:0] exp_w3;
        int n = 4;
        gold_list = '{32'h0};
        fill_expected(32'hFFFF_FFFE, n);
        golden_ready = 1'b1;
        load_work(32'hFFFF_FFFE, 32'h1);
        for (int c = 0; c <= int'(LAT) + n + 1; c++) begin
            if (c < 6) begin
                exp_w3 = (c < 4) ? 32'hFFFF_FFFE + 32'(c) : 32'h1;
                checks++; if (rx_input[127:96] !== exp_w3) begin errors++; $display("FAIL wrap_w3 c=%0d got=%h exp=%h", c, rx_input[127:96], exp_w3); end
            end
            checks++; if (done !== (c >= int'(LAT) + n)) begin errors++; $display("FAIL wrap_done c=%0d got=%b", c, done); end
            if (golden_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_extra got=%h exp=none", golden_nonce); end
                else begin
                    e = exp_q.pop_front();
                    if (golden_nonce !== e) begin errors++; $display("FAIL wrap_gnonce got=%h exp=%h", golden_nonce, e); end
                end
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_overflow;
        logic [31:0] e;
        int pops = 0;
        gold_list = '{32'h20, 32'h21, 32'h22};
        exp_q.delete();
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h21);
        golden_ready = 1'b0;
        load_work(32'h20, 32'h23);
        repeat (LAT + 4) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovf_done got=%b exp=1", done); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (golden_valid !== 1'b1) begin errors++; $display("FAIL ovf_gvalid got=%b exp=1", golden_valid); end
        golden_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (golden_valid === 1'b1) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL ovf_extra got=%h exp=none", golden_nonce); end
                else begin
                    e = exp_q.pop_front();
                    if (golden_nonce !== e) begin errors++; $display("FAIL ovf_gnonce got=%h exp=%h", golden_nonce, e); end
                end
            end
            @(negedge clk);
        end
        checks++; if (pops != 2) begin errors++; $display("FAIL ovf_pops got=%0d exp=2", pops); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reload;
        logic [31:0] e;
        gold_list.delete();
        for (int i = 0; i < 16; i++) gold_list.push_back(32'h200 + 32'(i));
        gold_list.push_back(32'h100);
        exp_q.delete();
        exp_q.push_back(32'h100);
        golden_ready = 1'b1;
        load_work(32'h200, 32'h20F);
        repeat (LAT) @(negedge clk);
        load_work(32'h100, 32'h100);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reload_ovf_clear got=%b exp=0", overflow); end
        for (int c = 0; c <= int'(LAT) + 4; c++) begin
            checks++; if (done !== (c >= int'(LAT) + 1)) begin errors++; $display("FAIL reload_done c=%0d got=%b", c, done); end
            if (golden_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL reload_stale got=%h exp=none", golden_nonce); end
                else begin
                    e = exp_q.pop_front();
                    if (golden_nonce !== e) begin errors++; $display("FAIL reload_gnonce got=%h exp=%h", golden_nonce, e); end
                end
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reload_missing got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        gold_list = '{32'h30, 32'h31};
        golden_ready = 1'b0;
        load_work(32'h30, 32'h3F);
        repeat (LAT + 3) @(negedge clk);
        checks++; if (golden_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_gvalid got=%b exp=1", golden_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (golden_valid !== 1'b0) begin errors++; $display("FAIL rmid_gvalid got=%b exp=0", golden_valid); end
        checks++; if (golden_nonce !== 32'h0) begin errors++; $display("FAIL rmid_gnonce got=%h exp=0", golden_nonce); end
        checks++; if (rx_state !== 256'h0) begin errors++; $display("FAIL rmid_rx_state got=%h exp=0", rx_state); end
        checks++; if (rx_input !== RST_RX) begin errors++; $display("FAIL rmid_rx_input got=%h exp=%h", rx_input, RST_RX); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_idle got busy=%b done=%b exp=0", busy, done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_reload();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
